// File: rtl/univ_shift_register.sv
// Purpose: WIDTH-bit universal register (hold/shift right/shift left/load) with serial I/O and saturating shift counter; optional rotate via UNIV_SHIFT_REGISTER_ROTATE_EN.
// Latency: one cycle from sampled inputs to q/cnt; sout_msb, sout_lsb and done decode registered state only.
// Backpressure: none; en=0 freezes all state, otherwise every edge applies the selected mode.
module univ_shift_register #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic             rot,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic             fill_msb;
    logic             fill_lsb;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;

`ifdef UNIV_SHIFT_REGISTER_ROTATE_EN
    // Bit entering each end: the opposite end of q when rotating, else the serial input
    always_comb begin
        fill_msb = rot ? q[0]       : sin_msb;
        fill_lsb = rot ? q[WIDTH-1] : sin_lsb;
    end
`else
    // rot has no effect in this build; keep it visibly consumed
    logic unused_rot;
    assign unused_rot = rot;

    // Bit entering each end always comes from the serial inputs
    always_comb begin
        fill_msb = sin_msb;
        fill_lsb = sin_lsb;
    end
`endif

    // Shift counter saturates at WIDTH so done stays high until the next load or reset
    always_comb begin
        cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end

    // Next register contents and count for the selected mode
    always_comb begin
        q_nxt   = q;
        cnt_nxt = cnt;
        case (mode)
            MODE_HOLD: begin
                q_nxt   = q;
                cnt_nxt = cnt;
            end
            MODE_SHR: begin
                q_nxt   = {fill_msb, q[WIDTH-1:1]};
                cnt_nxt = cnt_inc;
            end
            MODE_SHL: begin
                q_nxt   = {q[WIDTH-2:0], fill_lsb};
                cnt_nxt = cnt_inc;
            end
            MODE_LOAD: begin
                q_nxt   = d;
                cnt_nxt = '0;
            end
            default: begin
                q_nxt   = q;
                cnt_nxt = cnt;
            end
        endcase
    end

    // State register: reset wins over enable and mode
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= RST_VAL;
            cnt <= '0;
        end else if (en) begin
            q   <= q_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Serial outputs and done are pure decodes of registered state
    always_comb begin
        sout_msb = q[WIDTH-1];
        sout_lsb = q[0];
        done     = (cnt == CNT_MAX);
    end

endmodule

// File: tb/tb_univ_shift_register.sv
// Purpose: self-checking bench for univ_shift_register (WIDTH=8) using a reference model and an expected-value queue.
// Latency: each driven step expects its result one rising edge later, sampled 1 time unit after the edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_univ_shift_register;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic         sin_msb;
    logic         sin_lsb;
    logic         rot;
    logic [W-1:0] q;
    logic         sout_msb;
    logic         sout_lsb;
    logic [3:0]   cnt;
    logic         done;

    typedef struct {
        logic [W-1:0] q;
        logic [3:0]   cnt;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] mq;
    logic [3:0]   mc;
    int           n_chk;
    int           n_fail;

    univ_shift_register #(
        .WIDTH   (W),
        .RST_VAL (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .d        (d),
        .sin_msb  (sin_msb),
        .sin_lsb  (sin_lsb),
        .rot      (rot),
        .q        (q),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .cnt      (cnt),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run never reaches its summary
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, push the model's prediction, then compare after the edge
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [W-1:0] dd, input logic sm, input logic sl,
                        input logic ro);
        exp_t x;
        logic fm;
        logic fl;
        rst = r; en = e; mode = m; d = dd; sin_msb = sm; sin_lsb = sl; rot = ro;
`ifdef UNIV_SHIFT_REGISTER_ROTATE_EN
        fm = ro ? mq[0]   : sm;
        fl = ro ? mq[W-1] : sl;
`else
        fm = sm;
        fl = sl;
`endif
        if (r) begin
            mq = 8'h00;
            mc = 4'd0;
        end else if (e) begin
            if (m == 2'b11) begin
                mq = dd;
                mc = 4'd0;
            end else if (m != 2'b00) begin
                mq = (m == 2'b01) ? {fm, mq[W-1:1]} : {mq[W-2:0], fl};
                if (mc != 4'd8) mc = mc + 4'd1;
            end
        end
        x.q   = mq;
        x.cnt = mc;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            chk("q",        32'(q),        32'(x.q));
            chk("cnt",      32'(cnt),      32'(x.cnt));
            chk("done",     32'(done),     32'(x.cnt == 4'd8));
            chk("sout_msb", 32'(sout_msb), 32'(x.q[W-1]));
            chk("sout_lsb", 32'(sout_lsb), 32'(x.q[0]));
        end
    endtask

    logic [7:0] t2_out;
    logic [7:0] t3_in;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        mq = 8'h00;
        mc = 4'd0;
        rst = 1'b1; en = 1'b1; mode = 2'b11; d = 8'hFF;
        sin_msb = 1'b0; sin_lsb = 1'b0; rot = 1'b0;

        // 1. Reset overrides a pending load, then release loads FF
        step(1, 1, 2'b11, 8'hFF, 0, 0, 0);
        step(1, 1, 2'b11, 8'hFF, 0, 0, 0);
        chk("t1_rst_q", 32'(q), 32'h00);
        chk("t1_rst_cnt", 32'(cnt), 32'd0);
        chk("t1_rst_done", 32'(done), 32'd0);
        step(0, 1, 2'b11, 8'hFF, 0, 0, 0);
        chk("t1_load_q", 32'(q), 32'hFF);

        // 2. Load A5 and shift right: bits leaving sout_lsb follow 1,0,1,0,0,1,0,1
        step(0, 1, 2'b11, 8'hA5, 0, 0, 0);
        t2_out = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            chk("t2_sout_lsb", 32'(sout_lsb), 32'(t2_out[7-i]));
            step(0, 1, 2'b01, 8'h00, 0, 0, 0);
        end
        chk("t2_q", 32'(q), 32'h00);
        chk("t2_cnt", 32'(cnt), 32'd8);
        chk("t2_done", 32'(done), 32'd1);
        step(0, 1, 2'b01, 8'h00, 0, 0, 0);
        chk("t2_sat_cnt", 32'(cnt), 32'd8);

        // 3. Deserialise by shift left, then an immediate load clears done
        t3_in = 8'b1100_1010;
        for (int i = 0; i < 8; i++)
            step(0, 1, 2'b10, 8'h00, 0, t3_in[7-i], 0);
        chk("t3_q", 32'(q), 32'hCA);
        chk("t3_done", 32'(done), 32'd1);
        step(0, 1, 2'b11, 8'h3C, 0, 0, 0);
        chk("t3_load_q", 32'(q), 32'h3C);
        chk("t3_load_cnt", 32'(cnt), 32'd0);
        chk("t3_load_done", 32'(done), 32'd0);

        // 4. Enable gating holds q and cnt regardless of mode
        step(0, 1, 2'b11, 8'h81, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 2'b01, 8'h00, 1, 1, 0);
            chk("t4_hold_q", 32'(q), 32'h81);
            chk("t4_hold_cnt", 32'(cnt), 32'd0);
        end
        step(0, 1, 2'b01, 8'h00, 0, 0, 0);
        chk("t4_shr0_q", 32'(q), 32'h40);
        step(0, 1, 2'b11, 8'h81, 0, 0, 0);
        step(0, 1, 2'b01, 8'h00, 1, 0, 0);
        chk("t4_shr1_q", 32'(q), 32'hC0);

        // 5. Reset in the middle of a shift sequence
        step(0, 1, 2'b11, 8'hF0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 1, 2'b01, 8'h00, 0, 0, 0);
        chk("t5_mid_cnt", 32'(cnt), 32'd3);
        chk("t5_mid_q", 32'(q), 32'h1E);
        step(1, 1, 2'b01, 8'h00, 0, 0, 0);
        chk("t5_rst_q", 32'(q), 32'h00);
        chk("t5_rst_cnt", 32'(cnt), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);

        // 6. Rotate request: honoured only when the rotate build is selected
        step(0, 1, 2'b11, 8'h81, 0, 0, 0);
        step(0, 1, 2'b10, 8'h00, 0, 0, 1);
`ifdef UNIV_SHIFT_REGISTER_ROTATE_EN
        chk("t6_rol_q", 32'(q), 32'h03);
`else
        chk("t6_shl_q", 32'(q), 32'h02);
`endif
        step(0, 1, 2'b01, 8'h00, 0, 0, 1);
`ifdef UNIV_SHIFT_REGISTER_ROTATE_EN
        chk("t6_ror1_q", 32'(q), 32'h81);
`else
        chk("t6_shr1_q", 32'(q), 32'h01);
`endif
        step(0, 1, 2'b01, 8'h00, 0, 0, 1);
`ifdef UNIV_SHIFT_REGISTER_ROTATE_EN
        chk("t6_ror2_q", 32'(q), 32'hC0);
`else
        chk("t6_shr2_q", 32'(q), 32'h00);
`endif
        chk("t6_cnt", 32'(cnt), 32'd3);

        // Back-to-back random stream against the model
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
